// File: rtl/sign_addsub_pkg.sv
// Shared definitions for the sign-magnitude add/sub front end and core:
// framer FSM states, header bit positions and sign-magnitude field helpers.
package sign_addsub_pkg;

  typedef enum logic [1:0] {HDR, GET_A, GET_B, HOLD} fe_state_e;

  localparam int HDR_SYNC_BIT = 7;
  localparam int HDR_SUB_BIT  = 0;

  // Sign-magnitude layout: MSB is the sign, the rest is the magnitude.
  function automatic int sm_sign_bit(input int w);
    return w - 1;
  endfunction

  function automatic int sm_mag_msb(input int w);
    return w - 2;
  endfunction

endpackage

// File: rtl/sign_addsub_frontend_if.sv
// Byte-stream input and operand-pair output of the framer.
// slave = framer side, master = stream source / core side.
interface sign_addsub_frontend_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_sub;
  logic              op_valid;
  logic              op_ready;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_cnt;

  modport slave (
    input  in_data, in_valid, op_ready,
    output in_ready, op_a, op_b, op_sub, op_valid, frame_err, frame_cnt
  );

  modport master (
    output in_data, in_valid, op_ready,
    input  in_ready, op_a, op_b, op_sub, op_valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/sign_addsub_tmo.sv
// Inter-byte timeout counter. expired_o fires on the idle cycle that would
// bring the count to TIMEOUT; clr_i (byte accepted / idle state) always wins.
module sign_addsub_tmo #(
  parameter int TIMEOUT = 255,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && !clr_i && (cnt_q == W'(TIMEOUT - 1));

  // Next count: clear on accept/idle state or on expiry, else count idle cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expired_o) cnt_d = '0;
    else if (en_i)          cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sign_addsub_frontend.sv
// Frames a {header, A, B} byte stream into one operand pair for the
// sign-magnitude add/sub core, with a 1-deep output register, bad-header and
// inter-byte timeout detection, and a delivered-frame counter.
// Build option: SIGN_ADDSUB_2C_CONV_EN converts two's-complement A/B bytes to
// sign-magnitude at capture (most negative value saturates and flags frame_err).
module sign_addsub_frontend #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic                   clk,
  input logic                   rst,
  sign_addsub_frontend_if.slave bus
);
  import sign_addsub_pkg::*;

  fe_state_e         state_q;
  logic              sub_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic              op_sub_q, op_valid_q;
  logic              frame_err_q, in_ready_q;
  logic [CNT_W-1:0]  frame_cnt_q;

  logic              acc, drain, out_free, tmo_clr, tmo_en, tmo_exp;
  logic [DATA_W:0]   cap;  // {saturation flag, captured operand}

`ifdef SIGN_ADDSUB_2C_CONV_EN
  localparam int SGN     = sm_sign_bit(DATA_W);
  localparam int MAG_MSB = sm_mag_msb(DATA_W);

  function automatic logic [DATA_W:0] capture(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = -x;
    if (!x[SGN])                 capture = {1'b0, x};
    else if (x[MAG_MSB:0] == '0) capture = {1'b1, 1'b1, {(DATA_W-1){1'b1}}};
    else                         capture = {1'b0, 1'b1, neg[MAG_MSB:0]};
  endfunction
`else
  function automatic logic [DATA_W:0] capture(input logic [DATA_W-1:0] x);
    capture = {1'b0, x};
  endfunction
`endif

  assign cap      = capture(bus.in_data);
  assign acc      = bus.in_valid && in_ready_q;
  assign drain    = op_valid_q && bus.op_ready;
  assign out_free = !op_valid_q || bus.op_ready;
  assign tmo_clr  = acc || (state_q == HDR) || (state_q == HOLD);
  assign tmo_en   = (state_q == GET_A) || (state_q == GET_B);

  sign_addsub_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_exp)
  );

  // Framer FSM, staging registers, output register and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HDR;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sub_q    <= 1'b0;
      op_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      in_ready_q  <= 1'b1;
      if (drain) begin
        op_valid_q  <= 1'b0;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      case (state_q)
        HDR: if (acc) begin
          if (bus.in_data[HDR_SYNC_BIT]) begin
            sub_q   <= bus.in_data[HDR_SUB_BIT];
            state_q <= GET_A;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        GET_A: if (acc) begin
          a_q         <= cap[DATA_W-1:0];
          frame_err_q <= cap[DATA_W];
          state_q     <= GET_B;
        end else if (tmo_exp) begin
          frame_err_q <= 1'b1;
          state_q     <= HDR;
        end
        GET_B: if (acc) begin
          frame_err_q <= cap[DATA_W];
          if (out_free) begin
            // Load straight through; a same-edge drain leaves no bubble.
            op_a_q     <= a_q;
            op_b_q     <= cap[DATA_W-1:0];
            op_sub_q   <= sub_q;
            op_valid_q <= 1'b1;
            state_q    <= HDR;
          end else begin
            b_q        <= cap[DATA_W-1:0];
            in_ready_q <= 1'b0;
            state_q    <= HOLD;
          end
        end else if (tmo_exp) begin
          frame_err_q <= 1'b1;
          state_q     <= HDR;
        end
        HOLD: if (out_free) begin
          op_a_q     <= a_q;
          op_b_q     <= b_q;
          op_sub_q   <= sub_q;
          op_valid_q <= 1'b1;
          state_q    <= HDR;
        end else begin
          in_ready_q <= 1'b0;
        end
        default: state_q <= HDR;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_sub    = op_sub_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule
